ifu_fetch: RTL



---
 rtl/ifu_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch front end.
// Owns the fetch PC and keeps at most one instruction-memory request outstanding.
// Each returned word is buffered together with its PC and a static next-PC
// prediction: JAL targets are taken, and every other word predicts PC+4.
// The buffered instruction is handed to IF/ID under a valid/ready handshake.
// A redirect from execute restarts fetch at the new PC. Any word still in
// flight at that moment is dropped when it arrives.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,             // active-low, asserted asynchronously
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        imem_rsp_ready_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        f_valid_o,
  output logic [31:0] f_inst_o,
  output logic [31:0] f_pc_o,
  output logic [31:0] f_pred_pc_o,
  input  logic        D_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL  = 7'b1101111;

  state_e      state_q;
  logic [31:0] fetch_pc_q;   // address of the request being issued / awaited
  logic        drop_q;       // the in-flight response belongs to a flushed path
  logic [31:0] inst_q;
  logic [31:0] f_pc_q;
  logic [31:0] pred_q;

  logic        is_jal;
  logic [31:0] jal_imm;
  logic [31:0] pred_d;
  logic [31:0] redirect_pc_aligned;

  // Static prediction for the word arriving from memory at fetch_pc_q.
  always_comb begin
    is_jal  = (imem_rsp_data_i[6:0] == OPC_JAL);
    jal_imm = {{11{imem_rsp_data_i[31]}}, imem_rsp_data_i[31], imem_rsp_data_i[19:12],
               imem_rsp_data_i[20], imem_rsp_data_i[30:21], 1'b0};
    pred_d  = is_jal ? (fetch_pc_q + jal_imm) : (fetch_pc_q + 32'd4);
  end

  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};

  // Fetch FSM: owns the PC, the drop flag and the output instruction buffer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= NOP_INST;
      f_pc_q     <= 32'h0;
      pred_q     <= 32'h0;
    end else begin
      // A redirect overrides the PC in every state. In OUT it also
      // suppresses the sequential PC update further down.
      if (redirect_valid_i) begin
        fetch_pc_q <= redirect_pc_aligned;
      end
      case (state_q)
        IDLE: begin
          state_q <= REQ;
        end
        REQ: begin
          if (imem_req_ready_i) begin
            state_q <= WAIT;
            // The request was accepted at the old PC, so its answer must be dropped.
            drop_q  <= redirect_valid_i;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            if (drop_q || redirect_valid_i) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              inst_q  <= imem_rsp_data_i;
              f_pc_q  <= fetch_pc_q;
              pred_q  <= pred_d;
              state_q <= OUT;
            end
          end else if (redirect_valid_i) begin
            drop_q <= 1'b1;
          end
        end
        OUT: begin
          if (redirect_valid_i) begin
            state_q <= REQ;
          end else if (D_ready_i) begin
            fetch_pc_q <= pred_q;
            state_q    <= REQ;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid_o = (state_q == REQ);
  assign imem_req_addr_o  = fetch_pc_q;
  assign imem_rsp_ready_o = (state_q == WAIT);

  // The redirect cycle must never complete a downstream transfer.
  assign f_valid_o   = (state_q == OUT) && !redirect_valid_i;
  assign f_inst_o    = inst_q;
  assign f_pc_o      = f_pc_q;
  assign f_pred_pc_o = pred_q;

endmodule
